pipe_fd_de_regs: RTL
====================

// Module: pipe_fd_de_regs
// PURPOSE
//   Fetch-stage PC register plus IF/ID and ID/EX pipeline registers of the 5-stage RV32I core.
//   Consumes the stall/flush controls produced by the hazard unit (StallF, StallD, FlushD, FlushE).
//   Returns to the hazard unit the register indices and load flag it needs (Rs1D/Rs2D/Rs1E/Rs2E/RdE/ResultSrcE).
//   Counts stall and bubble cycles for performance debug.
// PARAMETERS
//   XLEN      32            datapath width
//   RESET_PC  32'h0000_0000 PCF value after reset
//   CNT_W     32            width of performance counters (saturating)
// PORTS
//   clk          in   1     core clock
//   reset        in   1     synchronous, active-high
//   StallF       in   1     hold PCF
//   StallD       in   1     hold IF/ID
//   FlushD       in   1     clear IF/ID to bubble
//   FlushE       in   1     clear ID/EX to bubble
//   PCSrcE       in   1     taken branch/jump resolved in E
//   PCTargetE    in   XLEN  redirect target
//   InstrF       in   32    instruction read at PCF
//   CtrlD        in   10    decode ctrl {RegWrite,ResultSrc[1:0],MemWrite,Jump,Branch,ALUControl[2:0],ALUSrc}
//   RD1D,RD2D    in   XLEN  register file read data
//   ImmExtD      in   XLEN  extended immediate
//   PCF          out  XLEN  fetch PC
//   InstrD       out  32    IF/ID instruction
//   PCD,PCPlus4D out  XLEN  IF/ID PC and PC+4
//   Rs1D,Rs2D    out  5     InstrD[19:15], InstrD[24:20] (combinational)
//   RdD          out  5     InstrD[11:7] (combinational)
//   CtrlE        out  10    ID/EX control, same bit layout as CtrlD
//   ResultSrcE   out  2     CtrlE[8:7], to hazard unit
//   RD1E,RD2E,ImmExtE,PCE,PCPlus4E out XLEN  ID/EX data
//   Rs1E,Rs2E,RdE out  5    ID/EX register indices
//   ValidD,ValidE out 1     stage holds a real (non-bubble) instruction
//   StallCnt     out  CNT_W cycles with StallD=1 and FlushD=0
//   BubbleCnt    out  CNT_W cycles with FlushE=1
// BEHAVIOUR
//   Reset (sync): PCF=RESET_PC; InstrD=32'h0000_0013 (nop); every other D/E register, ValidD, ValidE, counters = 0.
//   PC: PCSrcE=1 -> PCF<=PCTargetE, even when StallF=1 (a redirect always overrides stall);
//       else StallF=1 -> hold; else PCF<=PCF+4 (mod 2^XLEN, wraps).
//   IF/ID priority FlushD > StallD > load:
//       flush: InstrD<=nop, PCD<=0, PCPlus4D<=0, ValidD<=0;
//       stall: all IF/ID state holds;
//       load: InstrD<=InstrF, PCD<=PCF, PCPlus4D<=PCF+4, ValidD<=1.
//   ID/EX: FlushE=1 -> CtrlE, Rs1E, Rs2E, RdE, ValidE and all data fields <= 0; else load from D stage.
//       Load copies ValidD into ValidE; ID/EX has no stall input.
//   Latency: one cycle per register stage; Rs1D/Rs2D/RdD/ResultSrcE are pure functions of register state.
//   A zeroed CtrlE (RegWrite=0, MemWrite=0, Branch=0, Jump=0) is the bubble; it never writes the register file or memory.
//   StallD=1 and FlushD=1 together: the flush wins (wrong-path instruction discarded), and StallCnt does not count that cycle.
//   Counters: +1 on their condition; saturate at all-ones; clear only on reset.
//   Reset during a stall or flush: reset wins; the next cycle fetches RESET_PC with ValidD=0.
// TESTING
//   Reset then 3 free cycles -> PCF=0,4,8,12; InstrD=InstrF of the previous cycle; ValidD=1 from cycle 2.
//   Load-use: StallF=StallD=FlushE=1 for 1 cycle at PCF=0x10 -> PCF, InstrD held;
//       CtrlE=0, ValidE=0, RdE=0; StallCnt=1, BubbleCnt=1.
//   Taken branch: PCSrcE=1, PCTargetE=0x80, FlushD=FlushE=1 -> next cycle PCF=0x80, InstrD=0x00000013, ValidD=0, ValidE=0.
//   Redirect during stall: StallF=StallD=1 with PCSrcE=1, FlushD=1, PCTargetE=0x40 -> PCF=0x40;
//       IF/ID flushed; StallCnt unchanged.
//   PC wrap: force PCF=0xFFFF_FFFC, no stall -> PCF=0x0000_0000.
//   Counter saturation (CNT_W=4): hold FlushE=1 for 20 cycles -> BubbleCnt=4'hF and stays; reset -> 0.

Source files
------------

// File: rtl/pipe_fd_de_regs_if.sv
// Bundle of the fetch/decode/execute pipeline-register signals.
// The master side is the datapath plus hazard unit; the slave side is pipe_fd_de_regs.
// Stall/flush semantics: a stall holds a stage's register contents for that cycle.
// A flush replaces them with a bubble on the next edge, and a flush overrides a stall.
// There is no valid/ready handshake; a bubble is marked by ValidD/ValidE = 0.
interface pipe_fd_de_regs_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    // hazard controls and fetch/decode inputs
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic             PCSrcE;
    logic [XLEN-1:0]  PCTargetE;
    logic [31:0]      InstrF;
    logic [9:0]       CtrlD;
    logic [XLEN-1:0]  RD1D;
    logic [XLEN-1:0]  RD2D;
    logic [XLEN-1:0]  ImmExtD;

    // register-stage outputs
    logic [XLEN-1:0]  PCF;
    logic [31:0]      InstrD;
    logic [XLEN-1:0]  PCD;
    logic [XLEN-1:0]  PCPlus4D;
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       RdD;
    logic [9:0]       CtrlE;
    logic [1:0]       ResultSrcE;
    logic [XLEN-1:0]  RD1E;
    logic [XLEN-1:0]  RD2E;
    logic [XLEN-1:0]  ImmExtE;
    logic [XLEN-1:0]  PCE;
    logic [XLEN-1:0]  PCPlus4E;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic             ValidD;
    logic             ValidE;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] BubbleCnt;

    modport master (
        output StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE,
               InstrF, CtrlD, RD1D, RD2D, ImmExtD,
        input  PCF, InstrD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
               CtrlE, ResultSrcE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
               Rs1E, Rs2E, RdE, ValidD, ValidE, StallCnt, BubbleCnt
    );

    modport slave (
        input  StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE,
               InstrF, CtrlD, RD1D, RD2D, ImmExtD,
        output PCF, InstrD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
               CtrlE, ResultSrcE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
               Rs1E, Rs2E, RdE, ValidD, ValidE, StallCnt, BubbleCnt
    );
endinterface

// File: rtl/pipe_fd_de_regs.sv
// Fetch PC register, IF/ID and ID/EX pipeline registers of the RV32I core.
// The block also holds saturating stall and bubble performance counters.
module pipe_fd_de_regs #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    pipe_fd_de_regs_if.slave  bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0]  r_pcf;
    logic [31:0]      r_instrd;
    logic [XLEN-1:0]  r_pcd;
    logic [XLEN-1:0]  r_pcplus4d;
    logic             r_validd;
    logic [9:0]       r_ctrle;
    logic [XLEN-1:0]  r_rd1e;
    logic [XLEN-1:0]  r_rd2e;
    logic [XLEN-1:0]  r_immexte;
    logic [XLEN-1:0]  r_pce;
    logic [XLEN-1:0]  r_pcplus4e;
    logic [4:0]       r_rs1e;
    logic [4:0]       r_rs2e;
    logic [4:0]       r_rde;
    logic             r_valide;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic [XLEN-1:0]  w_pcplus4f;
    logic             w_stall_evt;

    assign w_pcplus4f  = r_pcf + XLEN'(4);
    // A stall that coincides with a flush discards the instruction, so it is not counted.
    assign w_stall_evt = bus.StallD & ~bus.FlushD;

    // Fetch PC: a redirect overrides a stall, and the increment wraps modulo 2^XLEN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcf <= RESET_PC;
        end else if (bus.PCSrcE) begin
            r_pcf <= bus.PCTargetE;
        end else if (!bus.StallF) begin
            r_pcf <= w_pcplus4f;
        end
    end

    // IF/ID register: a flush beats a stall, and a stall beats a load.
    always_ff @(posedge clk) begin
        if (reset || bus.FlushD) begin
            r_instrd   <= NOP;
            r_pcd      <= '0;
            r_pcplus4d <= '0;
            r_validd   <= 1'b0;
        end else if (!bus.StallD) begin
            r_instrd   <= bus.InstrF;
            r_pcd      <= r_pcf;
            r_pcplus4d <= w_pcplus4f;
            r_validd   <= 1'b1;
        end
    end

    // ID/EX register: it has no stall input, and a flush zeroes every field into a bubble.
    always_ff @(posedge clk) begin
        if (reset || bus.FlushE) begin
            r_ctrle    <= '0;
            r_rd1e     <= '0;
            r_rd2e     <= '0;
            r_immexte  <= '0;
            r_pce      <= '0;
            r_pcplus4e <= '0;
            r_rs1e     <= '0;
            r_rs2e     <= '0;
            r_rde      <= '0;
            r_valide   <= 1'b0;
        end else begin
            r_ctrle    <= bus.CtrlD;
            r_rd1e     <= bus.RD1D;
            r_rd2e     <= bus.RD2D;
            r_immexte  <= bus.ImmExtD;
            r_pce      <= r_pcd;
            r_pcplus4e <= r_pcplus4d;
            r_rs1e     <= r_instrd[19:15];
            r_rs2e     <= r_instrd[24:20];
            r_rde      <= r_instrd[11:7];
            r_valide   <= r_validd;
        end
    end

    // Performance counters: they saturate at all-ones and are cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (bus.FlushE && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign bus.PCF        = r_pcf;
    assign bus.InstrD     = r_instrd;
    assign bus.PCD        = r_pcd;
    assign bus.PCPlus4D   = r_pcplus4d;
    assign bus.Rs1D       = r_instrd[19:15];
    assign bus.Rs2D       = r_instrd[24:20];
    assign bus.RdD        = r_instrd[11:7];
    assign bus.CtrlE      = r_ctrle;
    assign bus.ResultSrcE = r_ctrle[8:7];
    assign bus.RD1E       = r_rd1e;
    assign bus.RD2E       = r_rd2e;
    assign bus.ImmExtE    = r_immexte;
    assign bus.PCE        = r_pce;
    assign bus.PCPlus4E   = r_pcplus4e;
    assign bus.Rs1E       = r_rs1e;
    assign bus.Rs2E       = r_rs2e;
    assign bus.RdE        = r_rde;
    assign bus.ValidD     = r_validd;
    assign bus.ValidE     = r_valide;
    assign bus.StallCnt   = r_stall_cnt;
    assign bus.BubbleCnt  = r_bubble_cnt;
endmodule
